corr_peak_detector: RTL

- Downstream of the autocorrelation stage. Consumes one correlation score per lag index and finds the lag with the highest score.
- Also reports the runner-up score and whether the peak is unique.
- Replaces the max-search loop currently done in the bench, so peak finding becomes synthesizable hardware.
- One scan covers SIZE lags, reports once, then idles until the next start.

---
 rtl/corr_peak_detector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/corr_peak_detector.sv
// corr_peak_detector: scans SIZE correlation scores, one per lag, and reports
// the lag of the maximum score, the runner-up score and whether the peak is unique.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin a new scan (clears trackers; ignored while reporting)
//   score_valid  score_in carries a sample this cycle
//   score_in     unsigned correlation score for the current lag
//   ready        high while scanning (samples accepted)
//   busy         high while scanning or reporting
//   done         one-cycle pulse, results are final
//   peak_pos     lag index of the maximum score (lowest lag on ties)
//   peak_score   maximum score
//   second_score largest score below the peak, or the peak itself on a tie
//   peak_unique  no other lag matched peak_score
//
// Optional feature, enabled by defining PEAK_THRESH_EN:
//   thresh       detection threshold (input)
//   detected     peak_score >= thresh and peak unique; holds until start/reset
module corr_peak_detector #(
  parameter int unsigned SIZE    = 256,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned IDX_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_in,
`ifdef PEAK_THRESH_EN
  input  logic [SCORE_W-1:0] thresh,
  output logic               detected,
`endif
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   peak_pos,
  output logic [SCORE_W-1:0] peak_score,
  output logic [SCORE_W-1:0] second_score,
  output logic               peak_unique
);

  localparam logic [IDX_W-1:0] LastLag = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic [SCORE_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic               tie_q, tie_d;
  logic [IDX_W-1:0]   lag_q, lag_d;
  logic               res_load;

  logic [IDX_W-1:0]   peak_pos_q;
  logic [SCORE_W-1:0] peak_score_q;
  logic [SCORE_W-1:0] second_score_q;
  logic               peak_unique_q;

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    second_d = second_q;
    pos_d    = pos_q;
    tie_d    = tie_q;
    lag_d    = lag_q;
    res_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StScan;
          max_d    = '0;
          second_d = '0;
          pos_d    = '0;
          tie_d    = 1'b0;
          lag_d    = '0;
        end
      end
      StScan: begin
        if (start) begin
          // Abort and restart; a sample presented alongside start is dropped.
          max_d    = '0;
          second_d = '0;
          pos_d    = '0;
          tie_d    = 1'b0;
          lag_d    = '0;
        end else if (score_valid) begin
          if (lag_q == '0) begin
            max_d    = score_in;
            pos_d    = '0;
            second_d = '0;
            tie_d    = 1'b0;
          end else if (score_in > max_q) begin
            second_d = max_q;
            max_d    = score_in;
            pos_d    = lag_q;
            tie_d    = 1'b0;
          end else if (score_in == max_q) begin
            // pos stays put so the lowest lag wins a tie
            tie_d    = 1'b1;
            second_d = score_in;
          end else if (score_in > second_q) begin
            second_d = score_in;
          end
          if (lag_q == LastLag) begin
            state_d  = StReport;
            // Publish on the same edge so results are valid while done is high
            res_load = 1'b1;
          end else begin
            lag_d = lag_q + IDX_W'(1);
          end
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      max_q          <= '0;
      second_q       <= '0;
      pos_q          <= '0;
      tie_q          <= 1'b0;
      lag_q          <= '0;
      peak_pos_q     <= '0;
      peak_score_q   <= '0;
      second_score_q <= '0;
      peak_unique_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      second_q <= second_d;
      pos_q    <= pos_d;
      tie_q    <= tie_d;
      lag_q    <= lag_d;
      if (res_load) begin
        peak_pos_q     <= pos_d;
        peak_score_q   <= max_d;
        second_score_q <= second_d;
        peak_unique_q  <= ~tie_d;
      end
    end
  end

`ifdef PEAK_THRESH_EN
  logic detected_q;
  logic start_clr;

  assign start_clr = start && (state_q != StReport);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      detected_q <= 1'b0;
    end else if (res_load) begin
      detected_q <= (max_d >= thresh) && !tie_d;
    end else if (start_clr) begin
      detected_q <= 1'b0;
    end
  end

  assign detected = detected_q;
`endif

  assign ready        = (state_q == StScan);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StReport);
  assign peak_pos     = peak_pos_q;
  assign peak_score   = peak_score_q;
  assign second_score = second_score_q;
  assign peak_unique  = peak_unique_q;

endmodule
